// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: walks the PC, handles decode stalls, branch
// redirects with a configurable bubble count, and a sticky end-of-program halt.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | one cycle after reset release, nothing fetched yet
//   FETCH  | pc presented and consumed, sequential advance each cycle
//   STALL  | decode hazard, pc held, refetched when the stall drops
//   FLUSH  | redirect bubbles, IF/ID squashed, pc already at branch target
//   HALT   | sequential fetch reached HALT_PC, left only through reset
module fetch_controller #(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] HALT_PC      = 32'd48,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_flag,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] nextpc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        stall_flag_out,
    output logic        halted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    // The entry cycle is one bubble, so the down-counter starts one short.
    localparam logic [1:0] BUB_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        flush_q, flush_d;
    logic        stall_out_q, stall_out_d;
    logic        halted_q, halted_d;
    logic [1:0]  bub_q, bub_d;

    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    assign pc_inc         = pc_q + 32'd4;
    assign target_aligned = branch_target & ~32'h3;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
        stall_out_d   = stall_flag;
        halted_d      = halted_q;
        bub_d         = bub_q;

        case (state_q)
            S_IDLE: begin
                state_d       = S_FETCH;
                fetch_valid_d = 1'b1;
                stall_out_d   = 1'b0;
            end
            S_FETCH, S_STALL: begin
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    flush_d = 1'b1;
                    bub_d   = BUB_LOAD;
                    state_d = S_FLUSH;
                end else if (stall_flag) begin
                    state_d = S_STALL;
                end else if (state_q == S_STALL) begin
                    state_d       = S_FETCH;
                    fetch_valid_d = 1'b1;
                end else if (pc_inc == HALT_PC) begin
                    pc_d     = HALT_PC;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d          = pc_inc;
                    fetch_valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    flush_d = 1'b1;
                    bub_d   = BUB_LOAD;
                end else if (bub_q == 2'd0) begin
                    state_d       = S_FETCH;
                    fetch_valid_d = 1'b1;
                end else begin
                    flush_d = 1'b1;
                    bub_d   = bub_q - 2'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            stall_out_q   <= 1'b0;
            halted_q      <= 1'b0;
            bub_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            stall_out_q   <= stall_out_d;
            halted_q      <= halted_d;
            bub_q         <= bub_d;
        end
    end

    assign pc             = pc_q;
    assign nextpc         = pc_inc;
    assign fetch_valid    = fetch_valid_q;
    assign flush          = flush_q;
    assign stall_flag_out = stall_out_q;
    assign halted         = halted_q;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: first fetch address after reset.
REQ-002 SHALL have parameter HALT_PC, default 32'd48: sequential address at which fetching stops.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..3: bubble cycles inserted after a redirect.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port stall_flag, input, 1: hazard stall request from decode.
REQ-007 SHALL have port branch_taken, input, 1: redirect request, valid for one cycle.
REQ-008 SHALL have port branch_target, input, 32: redirect byte address.
REQ-009 SHALL have port pc, output, 32: registered instruction-memory fetch address.
REQ-010 SHALL have port nextpc, output, 32: always pc + 4, modulo 2^32.
REQ-011 SHALL have port fetch_valid, output, 1: instruction at pc is to be consumed this cycle.
REQ-012 SHALL have port flush, output, 1: squash the IF/ID register contents.
REQ-013 SHALL have port stall_flag_out, output, 1: stall_flag registered by one cycle.
REQ-014 SHALL have port halted, output, 1: sticky end-of-program indicator.
REQ-015 SHALL drive every output except nextpc from flops.

Function
REQ-016 SHALL implement states IDLE, FETCH, STALL, FLUSH and HALT.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH; fetch_valid=0 in IDLE.
REQ-018 Input priority in FETCH and STALL SHALL be: branch_taken, then stall_flag, then sequential advance.
REQ-019 FETCH with branch_taken=1 SHALL load pc={branch_target[31:2],2'b00}, set flush=1, set fetch_valid=0 and enter FLUSH.
REQ-020 FETCH with stall_flag=1 (no branch) SHALL hold pc, set fetch_valid=0 and enter STALL.
REQ-021 FETCH otherwise SHALL set pc=pc+4 and fetch_valid=1; if pc+4 equals HALT_PC, it SHALL instead set pc=HALT_PC, fetch_valid=0, halted=1 and enter HALT.
REQ-022 STALL SHALL hold pc while stall_flag=1; on stall_flag=0 it SHALL return to FETCH with the same pc and fetch_valid=1 (refetch, no skipped address).
REQ-023 STALL with branch_taken=1 SHALL redirect exactly as REQ-019.
REQ-024 FLUSH SHALL keep flush=1 and fetch_valid=0 for FLUSH_CYCLES cycles total, ignore stall_flag, then enter FETCH at the target with fetch_valid=1.
REQ-025 branch_taken during FLUSH SHALL restart FLUSH with the new target and reload the bubble counter.
REQ-026 HALT SHALL be exited only by reset; branch_taken and stall_flag SHALL be ignored there.
REQ-027 pc increments SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-028 A redirect target equal to HALT_PC SHALL be fetched normally; halt is triggered only by a sequential advance.
REQ-029 stall_flag_out SHALL follow stall_flag with one-cycle latency in every state except IDLE.

Reset
REQ-030 While reset=1 the block SHALL immediately force: state=IDLE, pc=RESET_PC, fetch_valid=0, flush=0, stall_flag_out=0, halted=0, bubble counter=0.
REQ-031 Reset asserted mid-stall, mid-flush or in HALT SHALL abandon all pending actions; no redirect SHALL survive reset.

Verification
REQ-032 Reset, no stimulus -> pc 0, then 4, 8, ..., 44 with fetch_valid=1; the next cycle gives pc=48, halted=1, fetch_valid=0, held indefinitely.
REQ-033 stall_flag=1 for 3 cycles at pc=8 -> pc stays 8 and fetch_valid=0 for 3 cycles, then pc=8 with fetch_valid=1, then pc=12; stall_flag_out lags by one cycle.
REQ-034 branch_taken=1 with target 32'h22 at pc=12 -> pc=32'h20, flush=1 for exactly FLUSH_CYCLES cycles, then fetch_valid=1 at 32'h20.
REQ-035 branch_taken and stall_flag both set at pc=4 -> redirect taken, no STALL entry.
REQ-036 Asynchronous reset pulse mid-FLUSH, not aligned to clk -> outputs reach reset values before the next edge; sequence restarts at RESET_PC.
REQ-037 RESET_PC=32'hFFFF_FFF8, HALT_PC=32'd8 -> pc goes FFFF_FFF8, FFFF_FFFC, 0, 4, then halts at 8.
